// File: rtl/fu_branch_issue_sched.sv
// fu_branch_issue_sched
//   Reservation station and issue scheduler for the single branch FU.
//   It holds up to DEPTH dispatched BNE/JALR ops and tracks whether their
//   sources are ready, using CDB wakeups. Each cycle it issues the oldest
//   ready op (by ROB age) to the FU. On a mispredict it squashes every
//   buffered or in-flight op that is younger than the mispredicting branch.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   disp_valid/_ready   dispatch handshake (see below)
//   disp_data           op payload (rs_data)
//   disp_ps1/2_rdy      source already valid in the PRF at dispatch
//   cdb_valid/cdb_tag   result tag broadcast (wakeup)
//   rob_head            oldest ROB index; reference point for age
//   fu_ready            branch FU can accept an op this cycle
//   mispredict/_tag     branch resolved mispredicted; its ROB index
//   issued/issue_data   registered issue to the FU
//   occupancy           number of valid entries
//
// Handshake: an op transfers at a rising edge when disp_valid & disp_ready
//   and no mispredict is present. disp_ready depends only on registered
//   occupancy, so a slot freed by an issue at the same edge is not reused
//   until the next cycle.
//
// Configuration macro: FU_BRANCH_SCHED_WAKEUP_BYPASS_EN
//   If defined, a CDB hit makes an entry eligible at the same edge.
//   If undefined (the default), only registered ready bits are used.

package fu_branch_issue_sched_pkg;
   localparam int RS_ROB_W  = 5;
   localparam int RS_PREG_W = 7;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef struct packed {
      logic [6:0]           opcode;
      logic [2:0]           func3;
      logic [31:0]          pc;
      logic [31:0]          imm;
      logic [RS_PREG_W-1:0] pd;
      logic [RS_PREG_W-1:0] ps1;
      logic [RS_PREG_W-1:0] ps2;
      logic [RS_ROB_W-1:0]  rob_index;
   } rs_data;
endpackage

module fu_branch_issue_sched #(
   parameter int DEPTH  = 4,
   // The payload struct fixes these widths; keep them equal to the package values.
   parameter int ROB_W  = fu_branch_issue_sched_pkg::RS_ROB_W,
   parameter int PREG_W = fu_branch_issue_sched_pkg::RS_PREG_W
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               disp_valid,
   input  fu_branch_issue_sched_pkg::rs_data  disp_data,
   input  logic                               disp_ps1_rdy,
   input  logic                               disp_ps2_rdy,
   output logic                               disp_ready,
   input  logic                               cdb_valid,
   input  logic [PREG_W-1:0]                  cdb_tag,
   input  logic [ROB_W-1:0]                   rob_head,
   input  logic                               fu_ready,
   input  logic                               mispredict,
   input  logic [ROB_W-1:0]                   mispredict_tag,
   output logic                               issued,
   output fu_branch_issue_sched_pkg::rs_data  issue_data,
   output logic [$clog2(DEPTH+1)-1:0]         occupancy
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]                  valid_q, rdy1_q, rdy2_q;
   fu_branch_issue_sched_pkg::rs_data data_q [DEPTH];
   logic                              issued_q;
   fu_branch_issue_sched_pkg::rs_data issue_q;

   logic [ROB_W-1:0] age_e [DEPTH];
   logic [ROB_W-1:0] mp_age, issue_age;
   logic [DEPTH-1:0] hit1, hit2, elig, squash;
   logic             sel_found, free_found;
   logic [IDX_W-1:0] sel_idx, free_idx;
   logic [ROB_W-1:0] sel_age;
   logic             do_issue, do_disp;
   logic             disp_hit1, disp_hit2, disp_jalr;

   // Ages are differences from rob_head, so they wrap mod 2**ROB_W.
   assign mp_age    = mispredict_tag - rob_head;
   assign issue_age = issue_q.rob_index - rob_head;

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(valid_q[i]);
      end
   end

   assign disp_ready = (occupancy < OCC_W'(DEPTH));

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_e[i]  = data_q[i].rob_index - rob_head;
         hit1[i]   = cdb_valid && (data_q[i].ps1 == cdb_tag);
         hit2[i]   = cdb_valid && (data_q[i].ps2 == cdb_tag);
`ifdef FU_BRANCH_SCHED_WAKEUP_BYPASS_EN
         elig[i]   = valid_q[i] && (rdy1_q[i] || hit1[i]) && (rdy2_q[i] || hit2[i]);
`else
         elig[i]   = valid_q[i] && rdy1_q[i] && rdy2_q[i];
`endif
         squash[i] = mispredict && valid_q[i] && (age_e[i] > mp_age);
      end
   end

   // Oldest eligible entry. ROB indices in flight are unique, so ages never tie.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (elig[i] && (!sel_found || age_e[i] < sel_age)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_age   = age_e[i];
         end
      end
   end

   // Lowest-index free slot.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // A mispredict blocks both issue and dispatch. The dispatched op is
   // younger than the branch by construction, so dropping it is correct.
   assign do_issue  = !mispredict && fu_ready && sel_found;
   assign do_disp   = !mispredict && disp_valid && disp_ready && free_found;
   assign disp_hit1 = cdb_valid && (disp_data.ps1 == cdb_tag);
   assign disp_hit2 = cdb_valid && (disp_data.ps2 == cdb_tag);
   assign disp_jalr = (disp_data.opcode == fu_branch_issue_sched_pkg::OP_JALR);

   // An op already on its way to the FU is killed combinationally if it is
   // younger than the branch that is mispredicting now.
   assign issued     = issued_q && !(mispredict && (issue_age > mp_age));
   assign issue_data = issue_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= '0;
         rdy1_q   <= '0;
         rdy2_q   <= '0;
         issued_q <= 1'b0;
         issue_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         issued_q <= do_issue;
         if (do_issue) begin
            issue_q <= data_q[sel_idx];
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (hit1[i]) rdy1_q[i] <= 1'b1;
            if (hit2[i]) rdy2_q[i] <= 1'b1;
            if (squash[i] || (do_issue && sel_idx == IDX_W'(i))) begin
               valid_q[i] <= 1'b0;
            end
         end
         // The free slot is never issued or squashed, so this write wins cleanly.
         if (do_disp) begin
            valid_q[free_idx] <= 1'b1;
            data_q[free_idx]  <= disp_data;
            rdy1_q[free_idx]  <= disp_ps1_rdy || disp_hit1;
            rdy2_q[free_idx]  <= disp_ps2_rdy || disp_hit2 || disp_jalr;
         end
      end
   end
endmodule

// File: tb/tb_fu_branch_issue_sched.sv
// Testbench for fu_branch_issue_sched.
// The reference model keeps the buffered ops in a plain queue and applies the
// age, wakeup, issue and squash rules at every edge. One compare process checks
// the outputs at each falling edge. Directed scenarios add literal checks that
// pin down the expected issue order and timing.
module tb_fu_branch_issue_sched;
   import fu_branch_issue_sched_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_valid, disp_ps1_rdy, disp_ps2_rdy, disp_ready;
   rs_data      disp_data, issue_data;
   logic        cdb_valid;
   logic [6:0]  cdb_tag;
   logic [4:0]  rob_head, mispredict_tag;
   logic        fu_ready, mispredict, issued;
   logic [2:0]  occupancy;

   int n_cmp  = 0;
   int n_fail = 0;

   fu_branch_issue_sched #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_data(disp_data),
      .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy), .disp_ready(disp_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rob_head(rob_head),
      .fu_ready(fu_ready), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
      .issued(issued), .issue_data(issue_data), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      rs_data d;
      bit     r1;
      bit     r2;
   } m_ent_t;

   m_ent_t m_q[$];
   bit     m_issued = 1'b0;
   rs_data m_issue  = '0;

   function automatic int age(input logic [4:0] x, input logic [4:0] head);
      logic [4:0] d;
      d = x - head;
      return int'(d);
   endfunction

   task automatic model_edge();
      int     pre_size;
      int     sel;
      int     best;
      bit     e1, e2;
      m_ent_t n;
      pre_size = m_q.size();
      sel      = -1;
      best     = 0;
      if (mispredict) begin
         for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (age(m_q[i].d.rob_index, rob_head) > age(mispredict_tag, rob_head)) m_q.delete(i);
         end
         m_issued = 1'b0;
      end else begin
         if (fu_ready) begin
            for (int i = 0; i < m_q.size(); i++) begin
               e1 = m_q[i].r1;
               e2 = m_q[i].r2;
`ifdef FU_BRANCH_SCHED_WAKEUP_BYPASS_EN
               if (cdb_valid && m_q[i].d.ps1 == cdb_tag) e1 = 1'b1;
               if (cdb_valid && m_q[i].d.ps2 == cdb_tag) e2 = 1'b1;
`endif
               if (e1 && e2 && (sel < 0 || age(m_q[i].d.rob_index, rob_head) < best)) begin
                  sel  = i;
                  best = age(m_q[i].d.rob_index, rob_head);
               end
            end
         end
         if (sel >= 0) begin
            m_issued = 1'b1;
            m_issue  = m_q[sel].d;
            m_q.delete(sel);
         end else begin
            m_issued = 1'b0;
         end
      end
      for (int i = 0; i < m_q.size(); i++) begin
         if (cdb_valid && m_q[i].d.ps1 == cdb_tag) m_q[i].r1 = 1'b1;
         if (cdb_valid && m_q[i].d.ps2 == cdb_tag) m_q[i].r2 = 1'b1;
      end
      if (!mispredict && disp_valid && pre_size < DEPTH) begin
         n.d  = disp_data;
         n.r1 = disp_ps1_rdy || (cdb_valid && disp_data.ps1 == cdb_tag);
         n.r2 = disp_ps2_rdy || (cdb_valid && disp_data.ps2 == cdb_tag) ||
                (disp_data.opcode == 7'b1100111);
         m_q.push_back(n);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_issued = 1'b0;
         m_issue  = '0;
      end else begin
         model_edge();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      bit exp_iss;
      exp_iss = m_issued &&
                !(mispredict && age(m_issue.rob_index, rob_head) > age(mispredict_tag, rob_head));
      chk("cmp_issued", 128'(issued), 128'(exp_iss));
      chk("cmp_occupancy", 128'(occupancy), 128'(m_q.size()));
      chk("cmp_disp_ready", 128'(disp_ready), 128'(m_q.size() < DEPTH));
      chk("cmp_issue_data", 128'(issue_data), 128'(m_issue));
   end

   // ---------------- driver tasks ----------------
   function automatic rs_data mk(input logic [4:0] rob, input logic [6:0] p1,
                                 input logic [6:0] p2, input bit jalr);
      rs_data d;
      d.opcode    = jalr ? 7'b1100111 : 7'b1100011;
      d.func3     = 3'b001;
      d.pc        = 32'h1000 + 32'(rob) * 4;
      d.imm       = 32'h40 + 32'(rob);
      d.pd        = 7'(rob) + 7'd64;
      d.ps1       = p1;
      d.ps2       = p2;
      d.rob_index = rob;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input rs_data d, input bit r1, input bit r2);
      disp_valid   = 1'b1;
      disp_data    = d;
      disp_ps1_rdy = r1;
      disp_ps2_rdy = r2;
      tick();
      disp_valid   = 1'b0;
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      reset = 1'b0; disp_valid = 1'b0; disp_data = '0; disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0;
      cdb_valid = 1'b0; cdb_tag = '0; rob_head = '0; fu_ready = 1'b1;
      mispredict = 1'b0; mispredict_tag = '0;

      // 1: reset held with a dispatch presented
      disp_valid = 1'b1; disp_data = mk(9, 1, 2, 0); disp_ps1_rdy = 1'b1; disp_ps2_rdy = 1'b1;
      tick(); tick();
      chk("t1_issued", 128'(issued), 128'(0));
      chk("t1_occ", 128'(occupancy), 128'(0));
      chk("t1_disp_ready", 128'(disp_ready), 128'(1));
      disp_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("t1_occ_after", 128'(occupancy), 128'(0));

      // 2: ready BNE issues at the second edge; JALR ignores ps2
      disp(mk(2, 1, 2, 0), 1, 1);
      chk("t2_occ1", 128'(occupancy), 128'(1));
      chk("t2_not_yet", 128'(issued), 128'(0));
      tick();
      chk("t2_issued", 128'(issued), 128'(1));
      chk("t2_rob", 128'(issue_data.rob_index), 128'(2));
      chk("t2_payload", 128'(issue_data), 128'(mk(2, 1, 2, 0)));
      chk("t2_occ0", 128'(occupancy), 128'(0));
      tick();
      chk("t2_pulse", 128'(issued), 128'(0));
      disp(mk(3, 5, 9, 1), 1, 0);
      tick();
      chk("t2_jalr_issued", 128'(issued), 128'(1));
      chk("t2_jalr_rob", 128'(issue_data.rob_index), 128'(3));

      // 3: age order and CDB wakeup
      disp(mk(6, 10, 11, 0), 0, 1);
      disp(mk(4, 3, 4, 0), 1, 1);
      chk("t3_occ2", 128'(occupancy), 128'(2));
      tick();
      chk("t3_first", 128'(issue_data.rob_index), 128'(4));
      chk("t3_first_v", 128'(issued), 128'(1));
      cdb_valid = 1'b1; cdb_tag = 7'd10;
      tick();
      cdb_valid = 1'b0;
`ifdef FU_BRANCH_SCHED_WAKEUP_BYPASS_EN
      chk("t3_bypass_v", 128'(issued), 128'(1));
      chk("t3_bypass_rob", 128'(issue_data.rob_index), 128'(6));
`else
      chk("t3_wake_wait", 128'(issued), 128'(0));
      tick();
      chk("t3_wake_v", 128'(issued), 128'(1));
      chk("t3_wake_rob", 128'(issue_data.rob_index), 128'(6));
`endif
      tick();

      // 4: age wrap around rob 31 -> 0
      rob_head = 5'd30; fu_ready = 1'b0;
      disp(mk(1, 1, 2, 0), 1, 1);
      disp(mk(31, 1, 2, 0), 1, 1);
      disp(mk(0, 1, 2, 0), 1, 1);
      chk("t4_occ3", 128'(occupancy), 128'(3));
      fu_ready = 1'b1;
      tick(); chk("t4_first", 128'(issue_data.rob_index), 128'(31));
      tick(); chk("t4_second", 128'(issue_data.rob_index), 128'(0));
      tick(); chk("t4_third", 128'(issue_data.rob_index), 128'(1));
      chk("t4_occ0", 128'(occupancy), 128'(0));
      rob_head = 5'd0;
      tick();

      // 5: full and backpressure
      fu_ready = 1'b0;
      for (int r = 8; r < 12; r++) disp(mk(5'(r), 1, 2, 0), 1, 1);
      chk("t5_occ4", 128'(occupancy), 128'(4));
      chk("t5_full", 128'(disp_ready), 128'(0));
      disp_valid = 1'b1; disp_data = mk(12, 1, 2, 0);
      tick();
      chk("t5_rejected", 128'(occupancy), 128'(4));
      fu_ready = 1'b1;
      tick();
      chk("t5_iss8", 128'(issue_data.rob_index), 128'(8));
      chk("t5_occ3", 128'(occupancy), 128'(3));
      chk("t5_ready_again", 128'(disp_ready), 128'(1));
      tick();
      disp_valid = 1'b0;
      chk("t5_iss9", 128'(issue_data.rob_index), 128'(9));
      chk("t5_occ_same", 128'(occupancy), 128'(3));
      tick(); chk("t5_iss10", 128'(issue_data.rob_index), 128'(10));
      tick(); chk("t5_iss11", 128'(issue_data.rob_index), 128'(11));
      tick(); chk("t5_iss12", 128'(issue_data.rob_index), 128'(12));
      chk("t5_occ0", 128'(occupancy), 128'(0));
      tick();

      // 6: mispredict flush
      disp(mk(1, 20, 0, 0), 0, 1);
      disp(mk(3, 21, 0, 0), 0, 1);
      disp(mk(5, 22, 0, 0), 0, 1);
      disp(mk(4, 1, 2, 0), 1, 1);
      tick();
      chk("t6_iss4", 128'(issue_data.rob_index), 128'(4));
      chk("t6_iss4_v", 128'(issued), 128'(1));
      mispredict = 1'b1; mispredict_tag = 5'd2;
      disp_valid = 1'b1; disp_data = mk(7, 1, 2, 0); disp_ps1_rdy = 1'b1; disp_ps2_rdy = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 7'd20;
      #1;
      chk("t6_kill_inflight", 128'(issued), 128'(0));
      tick();
      mispredict = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
      chk("t6_occ1", 128'(occupancy), 128'(1));
      chk("t6_no_issue", 128'(issued), 128'(0));
      tick();
      chk("t6_iss1", 128'(issue_data.rob_index), 128'(1));
      chk("t6_iss1_v", 128'(issued), 128'(1));
      chk("t6_occ0", 128'(occupancy), 128'(0));

      // 7: reset mid-operation
      fu_ready = 1'b0;
      disp(mk(2, 1, 2, 0), 1, 1);
      disp(mk(3, 1, 2, 0), 1, 1);
      fu_ready = 1'b1;
      tick();
      chk("t7_iss2", 128'(issue_data.rob_index), 128'(2));
      reset = 1'b0;
      #1;
      chk("t7_occ", 128'(occupancy), 128'(0));
      chk("t7_issued", 128'(issued), 128'(0));
      chk("t7_data", 128'(issue_data), 128'(0));
      chk("t7_disp_ready", 128'(disp_ready), 128'(1));
      tick();
      reset = 1'b1;
      tick(); tick();
      chk("t7_stays_empty", 128'(occupancy), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
